// File: rtl/definitions_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, ALU ops and opcodes.
package definitions_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } ctrl_state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_sel_e;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LW) || (opc == OPC_SW);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct3/funct7 into an ALU operation and a legality flag.
module alu_decoder
    import definitions_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_sel_e   alu_sel,
    output logic       legal
);

    always_comb begin
        alu_sel = ALU_ADD;
        legal   = 1'b0;
        case (opcode)
            OPC_R: begin
                legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                case (funct3)
                    F3_ADD:  alu_sel = funct7[5] ? ALU_SUB : ALU_ADD;
                    F3_AND:  alu_sel = ALU_AND;
                    F3_OR:   alu_sel = ALU_OR;
                    F3_XOR:  alu_sel = ALU_XOR;
                    F3_SLT:  alu_sel = ALU_SLT;
                    default: legal   = 1'b0;
                endcase
            end
            // Immediate forms reuse funct7 bits as immediate, so they never select SUB.
            OPC_I: begin
                legal = 1'b1;
                case (funct3)
                    F3_ADD:  alu_sel = ALU_ADD;
                    F3_AND:  alu_sel = ALU_AND;
                    F3_OR:   alu_sel = ALU_OR;
                    F3_XOR:  alu_sel = ALU_XOR;
                    F3_SLT:  alu_sel = ALU_SLT;
                    default: legal   = 1'b0;
                endcase
            end
            OPC_BEQ: begin
                alu_sel = ALU_SUB;
                legal   = (funct3 == F3_BEQ);
            end
            OPC_LW, OPC_SW: begin
                alu_sel = ALU_ADD;
                legal   = (funct3 == F3_WORD);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: per-state datapath strobes, private IR copy,
// memory wait pacing with bus-error timeout, illegal-opcode trap and retire counter.
//
// state    | meaning
// S_FETCH  | capture instruction into ir_q
// S_DECODE | check opcode/funct legality
// S_EXEC   | drive ALU; BEQ retires here
// S_MEM    | hold load/store strobe until mem_ready or timeout
// S_WB     | register writeback, retire
// S_TRAP   | frozen until reset
module multicycle_control
    import definitions_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             alu_src,
    output alu_sel_e         alu_sel,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    ctrl_state_e       state;
    ctrl_state_e       state_nxt;
    logic [31:0]       ir_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic              mem_timeout;

    logic [6:0] opcode;
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    alu_sel_e   dec_alu_sel;
    logic       dec_legal;
    logic       unused_ir_fields;

    assign opcode = ir_q[6:0];
    assign is_r   = (opcode == OPC_R);
    assign is_lw  = (opcode == OPC_LW);
    assign is_sw  = (opcode == OPC_SW);
    assign is_beq = (opcode == OPC_BEQ);

    // Register and immediate fields belong to the datapath; only the control fields are decoded here.
    assign unused_ir_fields = ^{ir_q[24:15], ir_q[11:7]};

    alu_decoder u_alu_decoder (
        .opcode  (opcode),
        .funct3  (ir_q[14:12]),
        .funct7  (ir_q[31:25]),
        .alu_sel (dec_alu_sel),
        .legal   (dec_legal)
    );

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        mem_timeout = 1'b0;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_beq) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end else if (is_mem_op(opcode)) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            // A ready arriving on the last allowed cycle still completes the access.
            S_MEM: begin
                if (mem_ready) begin
                    if (is_sw) begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = S_TRAP;
                    mem_timeout = 1'b1;
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            ir_q      <= '0;
            wait_cnt  <= '0;
            instret   <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                ir_q <= instruction;
            end
            if ((state == S_DECODE) && !dec_legal) begin
                illegal <= 1'b1;
            end
            if (mem_timeout) begin
                bus_error <= 1'b1;
            end
            if (state == S_EXEC) begin
                wait_cnt <= '0;
            end else if ((state == S_MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    // Strobes are masked during reset so an aborted store never reaches the bus.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src    = 1'b0;
        alu_sel    = ALU_ADD;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: ir_write = 1'b1;
                S_EXEC: begin
                    alu_sel  = dec_alu_sel;
                    alu_src  = is_r || is_beq;
                    branch   = is_beq;
                    pc_write = is_beq;
                end
                S_MEM: begin
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    pc_write  = is_sw && mem_ready;
                end
                S_WB: begin
                    alu_sel    = dec_alu_sel;
                    alu_src    = is_r;
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle strobe vectors queued from a reference decode.
module tb_multicycle_control;
    import definitions_pkg::*;

    localparam int MEM_WAIT_MAX = 4;
    localparam int CNT_W        = 4;

    localparam int K_BAD = 0;
    localparam int K_R   = 1;
    localparam int K_I   = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;
    localparam int K_BEQ = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      instruction;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic             alu_src;
    alu_sel_e         alu_sel;
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             illegal;
    logic             bus_error;
    logic [CNT_W-1:0] instret;
    logic [10:0]      dut_vec;

    typedef struct packed {
        logic        rdy;
        logic [10:0] vec;
    } step_t;

    step_t            sb[$];
    int               n_checks = 0;
    int               n_errors = 0;
    string            cur_test;
    logic [CNT_W-1:0] exp_instret;
    logic             exp_illegal;
    logic             exp_bus_error;

    always #5 clk = ~clk;

    multicycle_control #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .mem_ready   (mem_ready),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .alu_src     (alu_src),
        .alu_sel     (alu_sel),
        .branch      (branch),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .illegal     (illegal),
        .bus_error   (bus_error),
        .instret     (instret)
    );

    assign dut_vec = {ir_write, pc_write, alu_src, alu_sel, branch,
                      mem_read, mem_write, mem_to_reg, reg_write};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic irw, input logic pcw, input logic src,
                                       input logic [2:0] sel, input logic br, input logic mrd,
                                       input logic mwr, input logic m2r, input logic rw);
        return {irw, pcw, src, sel, br, mrd, mwr, m2r, rw};
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output int kind, output logic [2:0] sel);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op   = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        kind = K_BAD;
        sel  = ALU_ADD;
        if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) begin
            kind = K_R;
            case (f3)
                3'd0:    sel = (f7 == 7'h20) ? ALU_SUB : ALU_ADD;
                3'd7:    sel = ALU_AND;
                3'd6:    sel = ALU_OR;
                3'd4:    sel = ALU_XOR;
                3'd2:    sel = ALU_SLT;
                default: kind = K_BAD;
            endcase
        end else if (op == 7'h13) begin
            kind = K_I;
            case (f3)
                3'd0:    sel = ALU_ADD;
                3'd7:    sel = ALU_AND;
                3'd6:    sel = ALU_OR;
                3'd4:    sel = ALU_XOR;
                3'd2:    sel = ALU_SLT;
                default: kind = K_BAD;
            endcase
        end else if (op == 7'h03 && f3 == 3'd2) begin
            kind = K_LW;
        end else if (op == 7'h23 && f3 == 3'd2) begin
            kind = K_SW;
        end else if (op == 7'h63 && f3 == 3'd0) begin
            kind = K_BEQ;
            sel  = ALU_SUB;
        end
    endfunction

    task automatic push(input logic rdy, input logic [10:0] v);
        step_t s;
        s.rdy = rdy;
        s.vec = v;
        sb.push_back(s);
    endtask

    task automatic push_instr(input logic [31:0] ins, input int waits);
        int         kind;
        logic [2:0] sel;
        logic       src;
        logic       lw;
        logic       sw;
        ref_decode(ins, kind, sel);
        src = (kind == K_R) || (kind == K_BEQ);
        lw  = (kind == K_LW);
        sw  = (kind == K_SW);
        push(1'b1, mk(1, 0, 0, ALU_ADD, 0, 0, 0, 0, 0));
        push(1'b1, 11'd0);
        if (kind == K_BAD) begin
            exp_illegal = 1'b1;
            repeat (3) push(1'($urandom_range(0, 1)), 11'd0);
        end else if (kind == K_BEQ) begin
            push(1'b1, mk(0, 1, 1, ALU_SUB, 1, 0, 0, 0, 0));
            exp_instret = exp_instret + 1'b1;
        end else if (kind == K_R || kind == K_I) begin
            push(1'b1, mk(0, 0, src, sel, 0, 0, 0, 0, 0));
            push(1'b1, mk(0, 1, src, sel, 0, 0, 0, 0, 1));
            exp_instret = exp_instret + 1'b1;
        end else begin
            push(1'b1, mk(0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0));
            for (int i = 0; i < waits && i < MEM_WAIT_MAX; i++)
                push(1'b0, mk(0, 0, 0, ALU_ADD, 0, lw, sw, 0, 0));
            if (waits >= MEM_WAIT_MAX) begin
                exp_bus_error = 1'b1;
                repeat (3) push(1'($urandom_range(0, 1)), 11'd0);
            end else begin
                push(1'b1, mk(0, sw, 0, ALU_ADD, 0, lw, sw, 0, 0));
                if (lw) push(1'b1, mk(0, 1, 0, ALU_ADD, 0, 0, 0, 1, 1));
                exp_instret = exp_instret + 1'b1;
            end
        end
    endtask

    task automatic run_queue();
        step_t s;
        int    idx;
        idx = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            mem_ready = s.rdy;
            @(negedge clk);
            chk($sformatf("%s.c%0d", cur_test, idx), 32'(dut_vec), 32'(s.vec));
            @(posedge clk);
            #1;
            idx++;
        end
    endtask

    task automatic check_flags(input string name);
        chk({name, ".instret"}, 32'(instret), 32'(exp_instret));
        chk({name, ".illegal"}, 32'(illegal), 32'(exp_illegal));
        chk({name, ".bus_error"}, 32'(bus_error), 32'(exp_bus_error));
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins, input int waits);
        cur_test    = name;
        instruction = ins;
        push_instr(ins, waits);
        run_queue();
        check_flags(name);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("reset.strobes", 32'(dut_vec), 32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        exp_instret   = '0;
        exp_illegal   = 1'b0;
        exp_bus_error = 1'b0;
        check_flags("reset");
    endtask

    logic [31:0] legal_list [8] = '{32'h002081B3, 32'h402081B3, 32'h00500093, 32'h0080A283,
                                    32'h0020A223, 32'h00208463, 32'h0020F1B3, 32'h0030A093};

    initial begin
        rst           = 1'b1;
        instruction   = '0;
        mem_ready     = 1'b0;
        exp_instret   = '0;
        exp_illegal   = 1'b0;
        exp_bus_error = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr("add",      32'h002081B3, 0);
        run_instr("sub",      32'h402081B3, 0);
        run_instr("and",      32'h0020F1B3, 0);
        run_instr("or",       32'h0020E1B3, 0);
        run_instr("xor",      32'h0020C1B3, 0);
        run_instr("slt",      32'h0020A1B3, 0);
        run_instr("addi",     32'h00500093, 0);
        run_instr("andi",     32'h0FF0F093, 0);
        run_instr("addi_neg", 32'hFFF08093, 0);
        run_instr("slti",     32'h0030A093, 0);
        run_instr("lw_w3",    32'h0080A283, 3);
        run_instr("sw_w0",    32'h0020A223, 0);
        run_instr("sw_w3",    32'h0020A223, 3);
        run_instr("beq",      32'h00208463, 0);

        run_instr("ill_mul",  32'h022081B3, 0);
        do_reset();
        run_instr("ill_bne",  32'h00209463, 0);
        do_reset();
        run_instr("ill_lb",   32'h00008283, 0);
        do_reset();
        run_instr("ill_slli", 32'h00109093, 0);
        do_reset();
        run_instr("ill_7f",   32'h0000007F, 0);
        do_reset();

        run_instr("sw_timeout", 32'h0020A223, 10);
        do_reset();

        cur_test    = "rst_mid_sw";
        instruction = 32'h0020A223;
        push(1'b1, mk(1, 0, 0, ALU_ADD, 0, 0, 0, 0, 0));
        push(1'b1, 11'd0);
        push(1'b1, mk(0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0));
        push(1'b0, mk(0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0));
        push(1'b0, mk(0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0));
        run_queue();
        do_reset();
        run_instr("post_rst_add", 32'h002081B3, 0);

        do_reset();
        for (int i = 0; i < 16; i++)
            run_instr($sformatf("wrap%0d", i), legal_list[i % 8], $urandom_range(0, 2));
        chk("wrap.zero", 32'(instret), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
